// File: rtl/trafficlight_phase_ctrl_if.sv
// Signal bundle for one approach of the phase sequencer. The walk request
// and lamp exist only when TRAFFICLIGHT_PED_REQUEST_EN is defined.
interface trafficlight_phase_ctrl_if;
  logic       emergency;
  logic [3:0] out;
  logic [2:0] phase;
  logic       allstop;
`ifdef TRAFFICLIGHT_PED_REQUEST_EN
  logic       ped_req;
  logic       ped_walk;

  modport master (output emergency, ped_req, input out, phase, allstop, ped_walk);
  modport slave  (input emergency, ped_req, output out, phase, allstop, ped_walk);
`else
  modport master (output emergency, input out, phase, allstop);
  modport slave  (input emergency, output out, phase, allstop);
`endif
endinterface

// File: rtl/trafficlight_phase_ctrl.sv
// Single-approach traffic-light phase sequencer with safe emergency pre-emption.
// Optional pedestrian walk logic is enabled by TRAFFICLIGHT_PED_REQUEST_EN.
module trafficlight_phase_ctrl #(
  parameter int       CNT_W        = 5,
  parameter int       LEFT_TIME    = 5,
  parameter int       GREEN_TIME   = 10,
  parameter int       YELLOW_TIME  = 3,
  parameter int       RED_TIME     = 18,
  parameter int       CLEAR_TIME   = 4,
  parameter logic [2:0] START_PHASE  = 3'd0,
  parameter logic [2:0] RESUME_PHASE = 3'd0,
  parameter int       WALK_TIME    = 6
) (
  input  logic                        clock,
  input  logic                        reset_n,
  trafficlight_phase_ctrl_if.slave    io
);

  typedef enum logic [2:0] {
    S_LEFT         = 3'd0,
    S_GREEN        = 3'd1,
    S_YELLOW       = 3'd2,
    S_RED          = 3'd3,
    S_EMERG_YELLOW = 3'd4,
    S_ALLSTOP      = 3'd5,
    S_CLEAR        = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(LEFT_TIME - 1);
  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GREEN_TIME - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(RED_TIME - 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLEAR_TIME - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last_cnt;
  logic             at_last;
  // Emergency seen mid-yellow: the yellow finishes, then heads to ALLSTOP.
  logic             yel_emerg;

  always_comb begin
    last_cnt = '0;
    case (state)
      S_LEFT:                   last_cnt = L_LAST;
      S_GREEN:                  last_cnt = G_LAST;
      S_YELLOW, S_EMERG_YELLOW: last_cnt = Y_LAST;
      S_RED:                    last_cnt = R_LAST;
      S_CLEAR:                  last_cnt = C_LAST;
      default:                  last_cnt = '0;
    endcase
    at_last = (cnt == last_cnt);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= state_t'(START_PHASE);
      cnt       <= '0;
      yel_emerg <= 1'b0;
    end else begin
      case (state)
        S_LEFT, S_GREEN: begin
          if (io.emergency) begin
            state <= S_EMERG_YELLOW;
            cnt   <= '0;
          end else if (at_last) begin
            state <= (state == S_LEFT) ? S_GREEN : S_YELLOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_YELLOW: begin
          if (at_last) begin
            state     <= (yel_emerg || io.emergency) ? S_ALLSTOP : S_RED;
            cnt       <= '0;
            yel_emerg <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (io.emergency) yel_emerg <= 1'b1;
          end
        end
        S_EMERG_YELLOW: begin
          if (at_last) begin
            state <= S_ALLSTOP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RED: begin
          if (io.emergency) begin
            state <= S_ALLSTOP;
            cnt   <= '0;
          end else if (at_last) begin
            state <= S_LEFT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_ALLSTOP: begin
          cnt <= '0;
          if (!io.emergency) state <= S_CLEAR;
        end
        S_CLEAR: begin
          if (io.emergency) begin
            state <= S_ALLSTOP;
            cnt   <= '0;
          end else if (at_last) begin
            state <= state_t'(RESUME_PHASE);
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= S_RED;
          cnt       <= '0;
          yel_emerg <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    io.out = 4'b0001;
    case (state)
      S_LEFT:                   io.out = 4'b1001;
      S_GREEN:                  io.out = 4'b0100;
      S_YELLOW, S_EMERG_YELLOW: io.out = 4'b0010;
      default:                  io.out = 4'b0001;
    endcase
    io.phase   = state;
    io.allstop = (state == S_ALLSTOP) || (state == S_CLEAR);
  end

`ifdef TRAFFICLIGHT_PED_REQUEST_EN
  // Walk never outlasts RED, so it cannot overlap the next LEFT.
  localparam int WALK_EFF  = (WALK_TIME < RED_TIME - 1) ? WALK_TIME : RED_TIME - 1;
  localparam int WALK_LST  = (WALK_EFF > 0) ? WALK_EFF - 1 : 0;
  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WALK_LST);

  logic             ped_pend;
  logic             walk;
  logic [CNT_W-1:0] wcnt;
  logic             red_entry;
  logic             emerg_entry;

  always_comb begin
    red_entry   = ((state == S_YELLOW) && at_last && !yel_emerg && !io.emergency) ||
                  (3'(state) == 3'd7);
    emerg_entry = (io.emergency && ((state == S_LEFT) || (state == S_GREEN) ||
                                    (state == S_RED)  || (state == S_CLEAR))) ||
                  ((state == S_YELLOW) && at_last && (yel_emerg || io.emergency)) ||
                  ((state == S_EMERG_YELLOW) && at_last) ||
                  ((state == S_ALLSTOP) && !io.emergency);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ped_pend <= 1'b0;
      walk     <= 1'b0;
      wcnt     <= '0;
    end else if (emerg_entry) begin
      ped_pend <= 1'b0;
      walk     <= 1'b0;
    end else if (red_entry && (ped_pend || io.ped_req) && (WALK_EFF > 0)) begin
      ped_pend <= 1'b0;
      walk     <= 1'b1;
      wcnt     <= '0;
    end else begin
      if (io.ped_req) ped_pend <= 1'b1;
      if (walk) begin
        if (wcnt == W_LAST) walk <= 1'b0;
        else                wcnt <= wcnt + CNT_W'(1);
      end
    end
  end

  assign io.ped_walk = walk;
`endif

endmodule

// File: doc/trafficlight_phase_ctrl.md
# trafficlight_phase_ctrl

Parametrised single-approach traffic-light phase sequencer, the next generation of the fixed-timing north-south/east-west light modules. Phase durations, start phase, post-emergency resume phase and counter width are parameters, so both approaches of an intersection are two instances of one module. Emergency pre-emption is safe: a green or left arrow always passes through yellow before all-stop, and a programmable all-red clearance precedes resumption.

## Interface
- `CNT_W`, 5: phase counter width; every `*_TIME` must be in the range 1..2^CNT_W.
- `LEFT_TIME`, 5: cycles in LEFT.
- `GREEN_TIME`, 10: cycles in GREEN.
- `YELLOW_TIME`, 3: cycles in YELLOW, and in EMERG_YELLOW.
- `RED_TIME`, 18: cycles in RED.
- `CLEAR_TIME`, 4: all-red cycles after emergency release.
- `START_PHASE`, 3'd0: phase after reset; 0=LEFT, 1=GREEN, 2=YELLOW, 3=RED.
- `RESUME_PHASE`, 3'd0: phase entered after CLEAR; same encoding.
- `WALK_TIME`, 6: walk cycles; used only with `PED_REQUEST_EN`.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `emergency` in 1: pre-emption request, level-sensitive, sampled at posedge.
- `out` out 4: lamp drive; [3] left arrow, [2] green, [1] yellow, [0] red.
- `phase` out 3: current state encoding.
- `allstop` out 1: high in ALLSTOP and CLEAR.
- `ped_req` in 1: pedestrian request pulse; present only with the macro.
- `ped_walk` out 1: walk lamp; present only with the macro.

## Operation
- States: LEFT(0), GREEN(1), YELLOW(2), RED(3), EMERG_YELLOW(4), ALLSTOP(5), CLEAR(6).
- `out` decode: LEFT=1001, GREEN=0100, YELLOW and EMERG_YELLOW=0010, RED, ALLSTOP and CLEAR=0001.
- Normal cycle: LEFT→GREEN→YELLOW→RED→LEFT. Each phase holds for exactly its `*_TIME` cycles (counter 0..TIME-1); the counter resets to 0 on every state change.
- Emergency high at a posedge:
  - In LEFT or GREEN: go to EMERG_YELLOW with counter 0.
  - In YELLOW or EMERG_YELLOW: finish the remaining yellow count, then go to ALLSTOP (never RED).
  - In RED: go to ALLSTOP immediately.
  - In CLEAR: return to ALLSTOP.
- ALLSTOP: held while `emergency`=1. When `emergency` is sampled 0, go to CLEAR.
- CLEAR: lasts CLEAR_TIME cycles, then goes to RESUME_PHASE with counter 0. An emergency during CLEAR returns to ALLSTOP.
- No state shows green or left arrow within fewer than YELLOW_TIME cycles of an emergency being sampled, unless the light was already red.
- Illegal state codes (7) recover to RED with counter 0 on the next clock.

## Timing
- Reset (async assert): state=START_PHASE, counter=0, `out`=decode(START_PHASE), `phase`=START_PHASE, `allstop`=0, `ped_walk`=0, request latch cleared.
- `out`, `phase` and `allstop` are combinational decodes of the state register. They change in the same cycle as the state, with no added latency.
- Emergency response: one posedge to the state change (for example, GREEN at edge k with emergency high shows `out`=0010 after edge k).
- Release: ALLSTOP→CLEAR at the first posedge with `emergency`=0. CLEAR ends CLEAR_TIME edges later.
- Reset deassertion is synchronised by the integrator; the block needs no internal synchroniser.

## Configuration
- `TRAFFICLIGHT_PED_REQUEST_EN` defined:
  - Adds `ped_req`/`ped_walk` and a 1-bit request latch, set by `ped_req`=1 at a posedge.
  - On entry to RED with the latch set: `ped_walk`=1 for min(WALK_TIME, RED_TIME-1) cycles, and the latch clears.
  - Entry to EMERG_YELLOW, ALLSTOP or CLEAR forces `ped_walk`=0 and clears the latch.
  - A request arriving during walk is latched for the next RED.
- Macro undefined: the ports are absent and the behaviour is identical apart from the walk logic.

## Test plan
- Defaults, START_PHASE=0, no emergency: `out` sequence 1001×5, 0100×10, 0010×3, 0001×18, then repeats. Period is 36 cycles.
- Emergency pulsed for 1 cycle at GREEN counter 4: 0010×3, then ALLSTOP for 1 cycle, CLEAR 0001×4, then LEFT 1001. `allstop`=1 throughout ALLSTOP and CLEAR.
- Emergency asserted in YELLOW at counter 1 and held 10 cycles: 0010 for 1 more cycle, then 0001 while held, then CLEAR×4, then RESUME_PHASE.
- Emergency re-asserted at CLEAR counter 2: returns to ALLSTOP. `out` stays 0001 and never shows 1001 or 0100.
- `reset_n` pulled low mid-GREEN between clock edges: `out` becomes decode(START_PHASE) immediately, and the counter restarts at 0 after release.
- With the macro: `ped_req` pulse during GREEN gives `ped_walk`=1 for the first 6 RED cycles. A second pulse during walk produces walk in the following RED.
